// File: rtl/ain_debouncer_pkg.sv
// Shared types and constants for the ain_debouncer input conditioner.
package ain_debouncer_pkg;

    typedef enum logic [1:0] {
        LOW_STABLE  = 2'd0,
        LOW_PEND    = 2'd1,
        HIGH_STABLE = 2'd2,
        HIGH_PEND   = 2'd3
    } deb_state_t;

    localparam logic [7:0] BOUNCE_MAX = 8'hFF;

endpackage

// File: rtl/input_sync.sv
// Multi-flop synchroniser bringing an asynchronous board input into the clk domain.
module input_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic i_async,
    output logic o_sync
);

    logic [SYNC_STAGES-1:0] r_chain;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[SYNC_STAGES-2:0], i_async};
        end
    end

    assign o_sync = r_chain[SYNC_STAGES-1];

endmodule

// File: rtl/ain_debouncer.sv
// Debounces a raw switch into a clean level with rise/fall strobes and a
// saturating count of rejected glitches.
module ain_debouncer
    import ain_debouncer_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_raw_in,
    output logic       o_ain,
    output logic       o_rise,
    output logic       o_fall,
    output logic [7:0] o_bounce_count
);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             w_s;
    deb_state_t       r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_ain, w_ain_nxt;
    logic             r_rise, w_rise_nxt;
    logic             r_fall, w_fall_nxt;
    logic             w_bounce_inc;
    logic [7:0]       r_bounce_count, w_bounce_nxt;

    input_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk    (clk),
        .reset  (reset),
        .i_async(i_raw_in),
        .o_sync (w_s)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= LOW_STABLE;
            r_cnt          <= '0;
            r_ain          <= 1'b0;
            r_rise         <= 1'b0;
            r_fall         <= 1'b0;
            r_bounce_count <= '0;
        end else begin
            r_state        <= w_state_nxt;
            r_cnt          <= w_cnt_nxt;
            r_ain          <= w_ain_nxt;
            r_rise         <= w_rise_nxt;
            r_fall         <= w_fall_nxt;
            r_bounce_count <= w_bounce_nxt;
        end
    end

    // cnt defaults to zero so every entry into a STABLE state clears it.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = '0;
        w_ain_nxt    = r_ain;
        w_rise_nxt   = 1'b0;
        w_fall_nxt   = 1'b0;
        w_bounce_inc = 1'b0;
        case (r_state)
            LOW_STABLE: begin
                if (w_s) begin
                    w_state_nxt = LOW_PEND;
                    w_cnt_nxt   = CNT_ONE;
                end
            end
            LOW_PEND: begin
                if (!w_s) begin
                    w_state_nxt  = LOW_STABLE;
                    w_bounce_inc = 1'b1;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = HIGH_STABLE;
                    w_ain_nxt   = 1'b1;
                    w_rise_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            HIGH_STABLE: begin
                if (!w_s) begin
                    w_state_nxt = HIGH_PEND;
                    w_cnt_nxt   = CNT_ONE;
                end
            end
            HIGH_PEND: begin
                if (w_s) begin
                    w_state_nxt  = HIGH_STABLE;
                    w_bounce_inc = 1'b1;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = LOW_STABLE;
                    w_ain_nxt   = 1'b0;
                    w_fall_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = LOW_STABLE;
                w_ain_nxt   = 1'b0;
            end
        endcase
        w_bounce_nxt = (w_bounce_inc && (r_bounce_count != BOUNCE_MAX))
                     ? r_bounce_count + 8'd1 : r_bounce_count;
    end

    assign o_ain          = r_ain;
    assign o_rise         = r_rise;
    assign o_fall         = r_fall;
    assign o_bounce_count = r_bounce_count;

endmodule

// File: tb/tb_ain_debouncer.sv
// Self-checking bench for ain_debouncer: directed scenarios plus random bounce
// against a run-length reference model.
module tb_ain_debouncer;

    localparam int unsigned SYNC = 2;
    localparam int unsigned DEB  = 16;
    localparam int unsigned LAT  = SYNC + DEB;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       raw_in = 1'b0;
    logic       ain, rise, fall;
    logic [7:0] bounce_count;

    int checks = 0;
    int errors = 0;

    // Reference model: sync delay line plus length of the current run of
    // samples disagreeing with the accepted level.
    bit m_sync [SYNC];
    bit m_ain, m_rise, m_fall;
    int m_run;
    int m_bc;

    int edge_no = 0;
    int last_rise_edge = -1;
    int last_fall_edge = -1;
    int n_rise = 0;
    int n_fall = 0;

    ain_debouncer #(
        .SYNC_STAGES    (SYNC),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .i_raw_in      (raw_in),
        .o_ain         (ain),
        .o_rise        (rise),
        .o_fall        (fall),
        .o_bounce_count(bounce_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < SYNC; i++) m_sync[i] = 1'b0;
        m_ain  = 1'b0;
        m_rise = 1'b0;
        m_fall = 1'b0;
        m_run  = 0;
        m_bc   = 0;
    endtask

    task automatic model_step();
        bit s;
        s = m_sync[SYNC-1];
        m_rise = 1'b0;
        m_fall = 1'b0;
        if (s != m_ain) begin
            m_run++;
            if (m_run == DEB) begin
                m_ain  = s;
                m_rise = s;
                m_fall = !s;
                m_run  = 0;
            end
        end else if (m_run > 0) begin
            if (m_bc < 255) m_bc++;
            m_run = 0;
        end
        for (int i = SYNC - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
        m_sync[0] = raw_in;
    endtask

    task automatic tick();
        @(posedge clk);
        edge_no++;
        if (reset) model_reset();
        else model_step();
        #1;
        check("ain", 32'(ain), 32'(m_ain));
        check("rise", 32'(rise), 32'(m_rise));
        check("fall", 32'(fall), 32'(m_fall));
        check("bounce_count", 32'(bounce_count), 32'(m_bc));
        check("rise_fall_overlap", 32'(rise & fall), 32'd0);
        if (rise === 1'b1) begin
            n_rise++;
            last_rise_edge = edge_no;
        end
        if (fall === 1'b1) begin
            n_fall++;
            last_fall_edge = edge_no;
        end
    endtask

    task automatic hold(input logic val, input int n);
        raw_in = val;
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int start;
        int rises_before;
        model_reset();

        // Reset state
        #2;
        check("reset_ain", 32'(ain), 32'd0);
        check("reset_rise", 32'(rise), 32'd0);
        check("reset_fall", 32'(fall), 32'd0);
        check("reset_bounce", 32'(bounce_count), 32'd0);
        tick();
        tick();
        reset = 1'b0;
        hold(1'b0, 5);

        // Clean rising step
        start = edge_no;
        hold(1'b1, 30);
        check("step_rise_latency", 32'(last_rise_edge - start), 32'(LAT));
        check("step_rise_count", 32'(n_rise), 32'd1);
        check("step_ain", 32'(ain), 32'd1);
        check("step_bounce", 32'(bounce_count), 32'd0);

        // Clean falling step
        start = edge_no;
        hold(1'b0, 30);
        check("step_fall_latency", 32'(last_fall_edge - start), 32'(LAT));
        check("step_fall_count", 32'(n_fall), 32'd1);
        check("fall_no_extra_rise", 32'(n_rise), 32'd1);
        check("fall_ain", 32'(ain), 32'd0);

        // Burst then steady high
        hold(1'b1, 5);
        hold(1'b0, 3);
        hold(1'b1, 7);
        hold(1'b0, 4);
        start = edge_no;
        hold(1'b1, 30);
        check("burst_bounces", 32'(bounce_count), 32'd2);
        check("burst_rise_latency", 32'(last_rise_edge - start), 32'(LAT));
        check("burst_rise_count", 32'(n_rise), 32'd2);

        // Back to low, then back-to-back accepted edges
        hold(1'b0, 30);
        hold(1'b1, 20);
        hold(1'b0, 40);
        check("b2b_spacing", 32'(last_fall_edge - last_rise_edge), 32'd20);
        check("b2b_bounce", 32'(bounce_count), 32'd2);

        // Reset in the middle of a pending rise
        hold(1'b1, SYNC + 10);
        reset = 1'b1;
        #1;
        check("midreset_ain", 32'(ain), 32'd0);
        check("midreset_rise", 32'(rise), 32'd0);
        check("midreset_bounce", 32'(bounce_count), 32'd0);
        tick();
        tick();
        reset = 1'b0;
        start = edge_no;
        hold(1'b1, 25);
        check("postreset_rise_latency", 32'(last_rise_edge - start), 32'(LAT));
        check("postreset_bounce", 32'(bounce_count), 32'd0);

        // Saturation with short pulses from low
        hold(1'b0, 30);
        rises_before = n_rise;
        for (int p = 0; p < 300; p++) begin
            hold(1'b1, 4);
            hold(1'b0, 30);
        end
        check("sat_bounce", 32'(bounce_count), 32'd255);
        check("sat_no_rise", 32'(n_rise - rises_before), 32'd0);
        check("sat_ain", 32'(ain), 32'd0);

        // Random bounce against the model (counter stays saturated, so reset first)
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int r = 0; r < 150; r++) begin
            hold(1'($urandom_range(0, 1)), int'($urandom_range(1, 24)));
        end
        hold(1'b0, 40);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
